// File: rtl/pipe_stage_reg_if.sv
// Bundle of control, upstream and stage-output signals for one pipeline register.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned EXC_W  = 5
);
  localparam int unsigned PC_W = 32;

  logic              req;
  logic              flush;
  logic              stall;
  logic              in_valid;
  logic [PC_W-1:0]   in_pc;
  logic              in_delay;
  logic [EXC_W-1:0]  in_exc;
  logic [EXC_W-1:0]  local_exc;
  logic [DATA_W-1:0] in_data;

  logic              out_valid;
  logic [PC_W-1:0]   out_pc;
  logic              out_delay;
  logic [EXC_W-1:0]  out_exc;
  logic [DATA_W-1:0] out_data;

  // Upstream/control side: drives inputs, observes stage contents.
  modport master (
    output req, flush, stall, in_valid, in_pc, in_delay, in_exc, local_exc, in_data,
    input  out_valid, out_pc, out_delay, out_exc, out_data
  );

  // Register side: samples inputs, presents stage contents.
  modport slave (
    input  req, flush, stall, in_valid, in_pc, in_delay, in_exc, local_exc, in_data,
    output out_valid, out_pc, out_delay, out_exc, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: payload, PC, delay-slot flag, valid and
// exception code, with hold (stall), bubble (flush) and handler redirect (req).
module pipe_stage_reg #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned EXC_W    = 5,
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave bus
);

  localparam int unsigned PC_W = 32;

  logic              valid_q, valid_d;
  logic [PC_W-1:0]   pc_q,    pc_d;
  logic              delay_q, delay_d;
  logic [EXC_W-1:0]  exc_q,   exc_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Earliest-stage exception wins; a non-instruction slot carries no exception.
  logic [EXC_W-1:0]  merged_exc_c;
  assign merged_exc_c = !bus.in_valid              ? EXC_W'(0)  :
                        (bus.in_exc != EXC_W'(0))  ? bus.in_exc :
                                                     bus.local_exc;

  // Next stage contents, priority req > flush > stall > load.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    delay_d = delay_q;
    exc_d   = exc_q;
    data_d  = data_q;
    if (bus.req) begin
      valid_d = 1'b0;
      pc_d    = EXC_PC;
      delay_d = 1'b0;
      exc_d   = EXC_W'(0);
      data_d  = DATA_W'(0);
    end else if (bus.flush) begin
      // Bubble keeps PC and delay flag so CP0 can still form EPC/BD.
      valid_d = 1'b0;
      pc_d    = bus.in_pc;
      delay_d = bus.in_delay;
      exc_d   = EXC_W'(0);
      data_d  = DATA_W'(0);
    end else if (!bus.stall) begin
      valid_d = bus.in_valid;
      pc_d    = bus.in_pc;
      delay_d = bus.in_delay;
      exc_d   = merged_exc_c;
      data_d  = bus.in_data;
    end
  end

  // Stage registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= PC_RESET;
      delay_q <= 1'b0;
      exc_q   <= EXC_W'(0);
      data_q  <= DATA_W'(0);
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      delay_q <= delay_d;
      exc_q   <= exc_d;
      data_q  <= data_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_pc    = pc_q;
  assign bus.out_delay = delay_q;
  assign bus.out_exc   = exc_q;
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, hand-written
// reset/parameter sequences, and randomized traffic against a reference model.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(32), .EXC_W(5)) bus ();
  pipe_stage_reg_if #(.DATA_W(8),  .EXC_W(3)) bus8 ();

  pipe_stage_reg #(.DATA_W(32), .EXC_W(5)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  pipe_stage_reg #(.DATA_W(8), .EXC_W(3), .PC_RESET(32'hBFC0_0000)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic v, input logic [31:0] pc,
                           input logic d, input logic [4:0] e, input logic [31:0] data);
    check({tag, ".valid"}, 64'(bus.out_valid), 64'(v));
    check({tag, ".pc"},    64'(bus.out_pc),    64'(pc));
    check({tag, ".delay"}, 64'(bus.out_delay), 64'(d));
    check({tag, ".exc"},   64'(bus.out_exc),   64'(e));
    check({tag, ".data"},  64'(bus.out_data),  64'(data));
  endtask

  typedef struct {
    logic        req, flush, stall, vld;
    logic [31:0] pc;
    logic        dly;
    logic [4:0]  exc, lexc;
    logic [31:0] data;
    logic        e_vld;
    logic [31:0] e_pc;
    logic        e_dly;
    logic [4:0]  e_exc;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[12];

  task automatic drive(input logic rq, input logic fl, input logic st, input logic v,
                       input logic [31:0] pc, input logic d, input logic [4:0] e,
                       input logic [4:0] le, input logic [31:0] data);
    bus.req = rq; bus.flush = fl; bus.stall = st; bus.in_valid = v;
    bus.in_pc = pc; bus.in_delay = d; bus.in_exc = e; bus.local_exc = le;
    bus.in_data = data;
  endtask

  // Reference model state: what the stage should hold after each edge.
  logic        m_v;
  logic [31:0] m_pc;
  logic        m_d;
  logic [4:0]  m_e;
  logic [31:0] m_data;

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 32'h0);
    bus8.req = 0; bus8.flush = 0; bus8.stall = 0; bus8.in_valid = 0;
    bus8.in_pc = 32'h0; bus8.in_delay = 0; bus8.in_exc = 3'd0; bus8.local_exc = 3'd0;
    bus8.in_data = 8'h00;

    #1;
    check_all("reset", 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("reset8.pc", 64'(bus8.out_pc), 64'(32'hBFC0_0000));

    @(negedge clk);
    reset = 1'b0;

    // req flush stall vld pc dly exc lexc data | valid pc dly exc data
    vecs[0]  = '{0,0,0,1,32'h3000,0,5'd0,5'd0,32'hDEAD_BEEF, 1,32'h3000,0,5'd0,32'hDEAD_BEEF};
    vecs[1]  = '{0,0,1,1,32'h3004,1,5'd3,5'd0,32'h0BAD_F00D, 1,32'h3000,0,5'd0,32'hDEAD_BEEF};
    vecs[2]  = '{0,0,1,1,32'h3004,1,5'd3,5'd0,32'h0BAD_F00D, 1,32'h3000,0,5'd0,32'hDEAD_BEEF};
    vecs[3]  = '{0,0,1,1,32'h3004,1,5'd3,5'd0,32'h0BAD_F00D, 1,32'h3000,0,5'd0,32'hDEAD_BEEF};
    vecs[4]  = '{0,0,0,1,32'h3004,1,5'd3,5'd0,32'h0BAD_F00D, 1,32'h3004,1,5'd3,32'h0BAD_F00D};
    vecs[5]  = '{0,1,0,1,32'h3010,1,5'd4,5'd0,32'h0000_1234, 0,32'h3010,1,5'd0,32'h0};
    vecs[6]  = '{1,1,1,1,32'h3020,1,5'd4,5'd2,32'h5555_AAAA, 0,32'h4180,0,5'd0,32'h0};
    vecs[7]  = '{1,0,0,1,32'h3024,1,5'd0,5'd0,32'h7777_7777, 0,32'h4180,0,5'd0,32'h0};
    vecs[8]  = '{0,0,0,1,32'h3030,0,5'd4,5'd12,32'h0000_0011, 1,32'h3030,0,5'd4,32'h0000_0011};
    vecs[9]  = '{0,0,0,1,32'h3034,0,5'd0,5'd12,32'h0000_0022, 1,32'h3034,0,5'd12,32'h0000_0022};
    vecs[10] = '{0,0,0,0,32'h3038,1,5'd4,5'd12,32'h0000_0033, 0,32'h3038,1,5'd0,32'h0000_0033};
    vecs[11] = '{0,1,1,1,32'h303C,0,5'd7,5'd1,32'hFFFF_FFFF, 0,32'h303C,0,5'd0,32'h0};

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].req, vecs[i].flush, vecs[i].stall, vecs[i].vld, vecs[i].pc,
            vecs[i].dly, vecs[i].exc, vecs[i].lexc, vecs[i].data);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_pc, vecs[i].e_dly,
                vecs[i].e_exc, vecs[i].e_data);
    end

    // Asynchronous reset mid-cycle, held across an edge, then released.
    drive(0, 0, 0, 1, 32'h3008, 0, 5'd0, 5'd0, 32'h0000_00AB);
    step();
    check("preRst.pc", 64'(bus.out_pc), 64'(32'h3008));
    #2;
    reset = 1'b1;
    #1;
    check("asyncRst.pc",    64'(bus.out_pc),    64'(32'h0));
    check("asyncRst.valid", 64'(bus.out_valid), 64'(1'b0));
    check("asyncRst8.pc",   64'(bus8.out_pc),   64'(32'hBFC0_0000));
    @(posedge clk);
    #1;
    check("holdRst.pc",    64'(bus.out_pc),    64'(32'h0));
    check("holdRst.valid", 64'(bus.out_valid), 64'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    bus8.in_valid = 1'b1;
    bus8.in_pc    = 32'h0000_0100;
    bus8.in_data  = 8'hA5;
    step();
    check("postRst.pc",    64'(bus.out_pc),     64'(32'h3008));
    check("postRst.valid", 64'(bus.out_valid),  64'(1'b1));
    check("sweep8.data",   64'(bus8.out_data),  64'(8'hA5));
    check("sweep8.pc",     64'(bus8.out_pc),    64'(32'h0000_0100));
    check("sweep8.valid",  64'(bus8.out_valid), 64'(1'b1));

    // Randomized traffic against the behavioural model, from a fresh reset.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    m_v = 1'b0; m_pc = 32'h0; m_d = 1'b0; m_e = 5'd0; m_data = 32'h0;
    for (int i = 0; i < 300; i++) begin
      logic        rq, fl, st, v, d;
      logic [31:0] pc, data;
      logic [4:0]  e, le;
      rq   = ($urandom_range(15, 0) == 0);
      fl   = ($urandom_range(7, 0) == 0);
      st   = ($urandom_range(3, 0) == 0);
      v    = 1'($urandom_range(1, 0));
      pc   = {$urandom_range(32'h3FFF, 0), 2'b00} & 32'hFFFF;
      d    = 1'($urandom_range(1, 0));
      e    = ($urandom_range(1, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
      le   = 5'($urandom_range(31, 0));
      data = $urandom;
      drive(rq, fl, st, v, pc, d, e, le, data);
      // Stage contents after the edge, straight from the priority rules.
      if (rq) begin
        m_v = 0; m_pc = 32'h0000_4180; m_d = 0; m_e = 0; m_data = 0;
      end else if (fl) begin
        m_v = 0; m_pc = pc; m_d = d; m_e = 0; m_data = 0;
      end else if (!st) begin
        m_v = v; m_pc = pc; m_d = d; m_data = data;
        if (!v)            m_e = 0;
        else if (e != 0)   m_e = e;
        else               m_e = le;
      end
      step();
      check_all($sformatf("rnd%0d", i), m_v, m_pc, m_d, m_e, m_data);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
